// File: rtl/sfifo_ext_if.sv
// -----------------------------------------------------------------------------
// sfifo_ext_if -- handshake/data bundle for the sfifo_ext single-clock FIFO.
//
// master modport (producer/consumer side) drives:
//   flush, w_en, data_in, r_en, clr_err
// slave modport (the FIFO) drives:
//   data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
//
// Parameters must match the sfifo_ext instance the bundle is attached to.
// -----------------------------------------------------------------------------
interface sfifo_ext_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7
) ();

  logic                  flush;
  logic                  w_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  r_en;
  logic                  clr_err;

  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, w_en, data_in, r_en, clr_err,
    input  data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  flush, w_en, data_in, r_en, clr_err,
    output data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

endinterface : sfifo_ext_if

// File: rtl/sfifo_ext.sv
// -----------------------------------------------------------------------------
// sfifo_ext -- single-clock FIFO with selectable standard / first-word-fall-
// through read mode, almost-full / almost-empty thresholds, sticky overflow /
// underflow flags, synchronous flush, and read+write accepted while full.
//
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset (pointers, count, flags, data_out)
//   io_fifo  : sfifo_ext_if.slave bundle
//     flush        in   synchronous clear of contents (priority over w_en/r_en)
//     w_en/data_in in   write request and data
//     r_en         in   read request (pop/acknowledge in FWFT mode)
//     clr_err      in   clears the sticky error flags (a new error wins)
//     data_out     out  read data (registered in standard mode, head word in FWFT)
//     full/empty/almost_full/almost_empty  out  decoded from count
//     count        out  number of stored words, 0..DEPTH
//     overflow/underflow  out  sticky rejected-write / rejected-read flags
//
// All DEPTH = 2**ADDR_WIDTH entries are usable; a separate count register
// disambiguates full from empty when the pointers are equal.
// -----------------------------------------------------------------------------
module sfifo_ext #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  sfifo_ext_if.slave   io_fifo
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LP_AF    = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] LP_AE    = (ADDR_WIDTH + 1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] LP_ONE_C = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] LP_ONE_P = ADDR_WIDTH'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_w_addr;
  logic [ADDR_WIDTH-1:0] r_r_addr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  // ---------------------------------------------------------------------------
  // Status decode and accept logic
  // ---------------------------------------------------------------------------
  logic w_full;
  logic w_empty;
  logic w_rd_ok;
  logic w_wr_ok;
  logic w_rd_fire;
  logic w_wr_fire;
  logic w_wr_err;
  logic w_rd_err;

  assign w_full  = (r_count == LP_DEPTH);
  assign w_empty = (r_count == '0);

  // A write into a full FIFO is still accepted when a read frees a slot in
  // the same cycle, so wr_ok depends on rd_ok.
  assign w_rd_ok = io_fifo.r_en & ~w_empty;
  assign w_wr_ok = io_fifo.w_en & (~w_full | w_rd_ok);

  // Flush swallows both requests: nothing moves and no error is raised.
  assign w_rd_fire = w_rd_ok & ~io_fifo.flush;
  assign w_wr_fire = w_wr_ok & ~io_fifo.flush;
  assign w_rd_err  = io_fifo.r_en & ~w_rd_ok & ~io_fifo.flush;
  assign w_wr_err  = io_fifo.w_en & ~w_wr_ok & ~io_fifo.flush;

  // ---------------------------------------------------------------------------
  // Pointers and occupancy
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w_addr <= '0;
      r_r_addr <= '0;
      r_count  <= '0;
    end else if (io_fifo.flush) begin
      r_w_addr <= '0;
      r_r_addr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_fire) r_w_addr <= r_w_addr + LP_ONE_P;
      if (w_rd_fire) r_r_addr <= r_r_addr + LP_ONE_P;
      unique case ({w_wr_fire, w_rd_fire})
        2'b10:   r_count <= r_count + LP_ONE_C;
        2'b01:   r_count <= r_count - LP_ONE_C;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset; stale words are unreachable because the
  // pointers and count are reset, and leaving it out keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (w_wr_fire) r_mem[r_w_addr] <= io_fifo.data_in;
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags: a new error in the same cycle as clr_err wins.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_err)             r_overflow <= 1'b1;
      else if (io_fifo.clr_err) r_overflow <= 1'b0;

      if (w_rd_err)             r_underflow <= 1'b1;
      else if (io_fifo.clr_err) r_underflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read data path
  // ---------------------------------------------------------------------------
  generate
    if (FWFT == 0) begin : g_std
      // Registered output: one clock of read latency; holds when idle/empty.
      logic [DATA_WIDTH-1:0] r_data_out;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_data_out <= '0;
        end else if (io_fifo.flush) begin
          r_data_out <= '0;
        end else if (w_rd_fire) begin
          r_data_out <= r_mem[r_r_addr];
        end
      end

      assign io_fifo.data_out = r_data_out;
    end else begin : g_fwft
      // Head word is presented combinationally; r_en acknowledges it.
      assign io_fifo.data_out = w_empty ? '0 : r_mem[r_r_addr];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Status outputs
  // ---------------------------------------------------------------------------
  assign io_fifo.full         = w_full;
  assign io_fifo.empty        = w_empty;
  assign io_fifo.almost_full  = (r_count >= LP_AF);
  assign io_fifo.almost_empty = (r_count <= LP_AE);
  assign io_fifo.count        = r_count;
  assign io_fifo.overflow     = r_overflow;
  assign io_fifo.underflow    = r_underflow;

endmodule : sfifo_ext

// File: tb/tb_sfifo_ext.sv
// -----------------------------------------------------------------------------
// tb_sfifo_ext -- self-checking bench for sfifo_ext.
// Two instances (standard and FWFT, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1) receive
// identical stimulus; a vector table holds per-cycle inputs and the expected
// state after the clock edge, followed by a hand-written async-reset sequence.
// -----------------------------------------------------------------------------
module tb_sfifo_ext;

  localparam int DW = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sfifo_ext_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_s ();
  sfifo_ext_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_f ();

  sfifo_ext #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(1)
  ) u_std (
    .clk     (clk),
    .rst_n   (rst_n),
    .io_fifo (bus_s.slave)
  );

  sfifo_ext #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(1)
  ) u_fw (
    .clk     (clk),
    .rst_n   (rst_n),
    .io_fifo (bus_f.slave)
  );

  typedef struct {
    logic          fl;
    logic          we;
    logic          re;
    logic          ce;
    logic [DW-1:0] din;
    int            cnt;
    logic          ovf;
    logic          unf;
    logic [DW-1:0] ds;   // expected data_out, standard instance
    logic [DW-1:0] df;   // expected data_out, FWFT instance
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input logic fl, we, re, ce, input logic [DW-1:0] din,
                              input int cnt, input logic ovf, unf,
                              input logic [DW-1:0] ds, df);
    vec_t v;
    v.fl = fl; v.we = we; v.re = re; v.ce = ce; v.din = din;
    v.cnt = cnt; v.ovf = ovf; v.unf = unf; v.ds = ds; v.df = df;
    return v;
  endfunction

  task automatic drive(input logic fl, we, re, ce, input logic [DW-1:0] din);
    bus_s.flush = fl; bus_s.w_en = we; bus_s.r_en = re; bus_s.clr_err = ce;
    bus_s.data_in = din;
    bus_f.flush = fl; bus_f.w_en = we; bus_f.r_en = re; bus_f.clr_err = ce;
    bus_f.data_in = din;
  endtask

  task automatic check(input string name, input logic [31:0] act, exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Flags follow from the expected count: DEPTH=8, AF_LEVEL=6, AE_LEVEL=1.
  task automatic check_state(input string tag, input int cnt, input logic ovf, unf,
                             input logic [DW-1:0] ds, df);
    check({tag, " std.count"},        32'(bus_s.count),        32'(cnt));
    check({tag, " std.full"},         32'(bus_s.full),         32'(cnt == 8));
    check({tag, " std.empty"},        32'(bus_s.empty),        32'(cnt == 0));
    check({tag, " std.almost_full"},  32'(bus_s.almost_full),  32'(cnt >= 6));
    check({tag, " std.almost_empty"}, 32'(bus_s.almost_empty), 32'(cnt <= 1));
    check({tag, " std.overflow"},     32'(bus_s.overflow),     32'(ovf));
    check({tag, " std.underflow"},    32'(bus_s.underflow),    32'(unf));
    check({tag, " std.data_out"},     32'(bus_s.data_out),     32'(ds));
    check({tag, " fw.count"},         32'(bus_f.count),        32'(cnt));
    check({tag, " fw.empty"},         32'(bus_f.empty),        32'(cnt == 0));
    check({tag, " fw.overflow"},      32'(bus_f.overflow),     32'(ovf));
    check({tag, " fw.underflow"},     32'(bus_f.underflow),    32'(unf));
    check({tag, " fw.data_out"},      32'(bus_f.data_out),     32'(df));
  endtask

  initial begin
    // 1: fill 0x01..0x08, then a rejected 9th write.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 1, 0, 0, DW'(i + 1), i + 1, 0, 0, 8'h00, 8'h01));
    vecs.push_back(mk(0, 1, 0, 0, 8'h09, 8, 1, 0, 8'h00, 8'h01));
    // 2: clear error, read+write while full, then drain across the wrap.
    vecs.push_back(mk(0, 0, 0, 1, 8'h00, 8, 0, 0, 8'h00, 8'h01));
    vecs.push_back(mk(0, 1, 1, 0, 8'hAA, 8, 0, 0, 8'h01, 8'h02));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 7, 0, 0, 8'h02, 8'h03));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 6, 0, 0, 8'h03, 8'h04));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 5, 0, 0, 8'h04, 8'h05));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 4, 0, 0, 8'h05, 8'h06));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 3, 0, 0, 8'h06, 8'h07));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 2, 0, 0, 8'h07, 8'h08));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 1, 0, 0, 8'h08, 8'hAA));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 0, 0, 0, 8'hAA, 8'h00));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 0, 0, 1, 8'hAA, 8'h00));
    vecs.push_back(mk(0, 0, 0, 1, 8'h00, 0, 0, 0, 8'hAA, 8'h00));
    // 3: single word fall-through, pop, then read on empty.
    vecs.push_back(mk(0, 1, 0, 0, 8'h5C, 1, 0, 0, 8'hAA, 8'h5C));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 0, 0, 0, 8'h5C, 8'h00));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 0, 0, 1, 8'h5C, 8'h00));
    vecs.push_back(mk(0, 0, 0, 1, 8'h00, 0, 0, 0, 8'h5C, 8'h00));
    // 4: five words, then flush with w_en and r_en also high.
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 1, 0, 0, DW'((i + 1) * 8'h11), i + 1, 0, 0, 8'h5C, 8'h11));
    vecs.push_back(mk(1, 1, 1, 0, 8'h66, 0, 0, 0, 8'h00, 8'h00));
    // 5: set both errors, clear alone, then clear colliding with a new overflow.
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 0, 0, 1, 8'h00, 8'h00));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 1, 0, 0, DW'(8'h80 + i), i + 1, 0, 1, 8'h00, 8'h80));
    vecs.push_back(mk(0, 1, 0, 0, 8'h88, 8, 1, 1, 8'h00, 8'h80));
    vecs.push_back(mk(0, 0, 0, 1, 8'h00, 8, 0, 0, 8'h00, 8'h80));
    vecs.push_back(mk(0, 1, 0, 1, 8'h99, 8, 1, 0, 8'h00, 8'h80));
    // Drain to count = 4 ahead of the async reset sequence.
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0, 1, 0, 8'h00, 7 - i, 1, 0, DW'(8'h80 + i), DW'(8'h81 + i)));

    // Reset state.
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 0, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].fl, vecs[i].we, vecs[i].re, vecs[i].ce, vecs[i].din);
      @(posedge clk);
      #1;
      check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ovf, vecs[i].unf,
                  vecs[i].ds, vecs[i].df);
    end

    // 6: async reset between edges while a read is pending at count = 4.
    drive(0, 0, 1, 0, 8'h00);
    #1;
    rst_n = 1'b0;
    #1;
    check_state("async_rst", 0, 0, 0, 8'h00, 8'h00);
    drive(0, 0, 0, 0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    drive(0, 1, 0, 0, 8'h33);
    @(posedge clk);
    #1;
    check_state("post_rst_wr", 1, 0, 0, 8'h00, 8'h33);
    drive(0, 0, 1, 0, 8'h00);
    @(posedge clk);
    #1;
    check_state("post_rst_rd", 0, 0, 0, 8'h33, 8'h00);
    drive(0, 0, 0, 0, 8'h00);
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_sfifo_ext

// File: doc/sfifo_ext.md
Name: sfifo_ext

Overview:
- Next-generation single-clock FIFO for buffering streams between pipeline stages in the same clock domain.
- Generalises the existing synchronous FIFO with:
  - a selectable first-word-fall-through (FWFT) read mode;
  - almost-full and almost-empty thresholds;
  - sticky overflow and underflow error flags;
  - a synchronous flush;
  - simultaneous read and write accepted while full.
- Storage is a register array of 2**ADDR_WIDTH entries, and every entry is usable.

Parameters:
- DATA_WIDTH, 8, width of each data word.
- ADDR_WIDTH, 7, pointer width. DEPTH = 2**ADDR_WIDTH entries.
- FWFT, 0, read mode. 0 = standard (registered output, 1-clk read latency); 1 = first-word-fall-through.
- AF_LEVEL, DEPTH-2, almost_full threshold. Legal range 1..DEPTH.
- AE_LEVEL, 2, almost_empty threshold. Legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of FIFO contents.
- w_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- r_en  in  1  read request. In FWFT mode it acts as the pop/acknowledge of data_out.
- data_out  out  DATA_WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDR_WIDTH+1  current number of stored words.
- overflow  out  1  sticky; set by a rejected write.
- underflow  out  1  sticky; set by a rejected read.
- clr_err  in  1  clears overflow and underflow.

Behaviour:
- Reset (async, rst_n low):
  - w_addr = r_addr = 0, count = 0, data_out = 0, overflow = underflow = 0.
  - Outputs therefore reset to empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - Memory contents are not reset and are undefined.
  - Asserting reset mid-operation discards all contents immediately.
- Accept conditions (combinational, evaluated each clk):
  - rd_ok = r_en & ~empty.
  - wr_ok = w_en & (~full | rd_ok). A write to a full FIFO succeeds when it coincides with an accepted read.
- Write: on wr_ok, mem[w_addr] <= data_in and w_addr <= w_addr + 1. Pointers wrap modulo DEPTH naturally.
- Read: on rd_ok, r_addr <= r_addr + 1.
- Count update:
  - count + 1 if wr_ok & ~rd_ok.
  - count - 1 if rd_ok & ~wr_ok.
  - Otherwise unchanged.
  - count never exceeds DEPTH and never goes below 0.
- All flags decode combinationally from the count register, so each flag changes on the clk edge that changes count.
- FWFT = 0 (standard mode):
  - On rd_ok, data_out <= mem[r_addr], visible 1 clk after the request.
  - data_out holds its value otherwise, including while empty.
  - A write into an empty FIFO needs 1 clk before empty = 0, so the earliest read data appears 2 clks after the write.
- FWFT = 1 (first-word-fall-through mode):
  - data_out = empty ? 0 : mem[r_addr], driven combinationally from the registered r_addr and count.
  - The head word is visible whenever empty = 0, and r_en pops it.
  - A word written into an empty FIFO appears on data_out 1 clk after the write edge.
- Overflow and underflow flags:
  - overflow is set on any cycle with w_en & ~wr_ok.
  - underflow is set on any cycle with r_en & ~rd_ok.
  - Both flags stay set until clr_err.
  - If clr_err coincides with a new error event, the set wins.
  - A rejected write or read changes neither the pointers nor memory.
- Flush:
  - On flush = 1, w_addr, r_addr and count go to 0 at the next edge.
  - data_out goes to 0 in standard mode.
  - Flush has priority over w_en and r_en in the same cycle; those requests are ignored and raise no error flags.
  - Flush leaves the error flags unchanged.
- Mode combinations:
  - Simultaneous read and write when empty: only the write is accepted; underflow is set if r_en = 1.
  - Simultaneous read and write at any other level: both are accepted and count is unchanged.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=3 so DEPTH=8, AF_LEVEL=6, AE_LEVEL=1):
1. Reset, then write 0x01..0x08 in 8 consecutive clks:
   - almost_empty falls after the 2nd write; almost_full rises after the 6th write.
   - full = 1 and count = 8 after the 8th write.
   - A 9th write of 0x09 sets overflow, leaves count = 8 and is never read back.
2. From the full state, assert w_en = r_en with data 0xAA for 1 clk:
   - count stays 8, full stays 1 and overflow stays 0.
   - With FWFT = 0, data_out = 0x01 the next clk.
   - Draining all 8 words gives 0x02..0x08 then 0xAA, which also checks pointer wrap.
3. FWFT = 1, from empty, write 0x5C:
   - 1 clk later empty = 0 and data_out = 0x5C with no r_en.
   - Pulse r_en: empty = 1 and data_out = 0 the next clk.
   - Pulse r_en again: underflow = 1 and count stays 0.
4. Fill with 5 words, then assert flush together with w_en and r_en:
   - Next clk count = 0, empty = 1, almost_empty = 1 and data_out = 0 (standard mode).
   - overflow and underflow remain 0.
5. Pulse clr_err alone: both sticky flags clear. Pulse clr_err in the same clk as a rejected write: overflow = 1.
6. Assert rst_n low asynchronously, between clock edges, while at count = 4 with a read in progress:
   - All outputs take their reset values immediately, without waiting for a clk edge.
   - After release, a fresh write of 0x33 and a read return 0x33.
